// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared constants and scan state type for the SAD scan controller
package sad_pkg;
   localparam int IMG_W      = 640;
   localparam int IMG_H      = 480;
   localparam int TPL_W      = 40;
   localparam int TPL_H      = 40;
   localparam int N_FLAG     = IMG_W - TPL_W;
   localparam int SAD_THRESH = 500;
   localparam int PIPE_LAT   = 2;
   localparam int ROW_AW     = $clog2(IMG_H);
   localparam int TPL_AW     = $clog2(TPL_W * TPL_H);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_STREAM,
      S_ROWCHG,
      S_WAIT,
      S_REPORT,
      S_DONE
   } scan_state_t;
endpackage

// File: rtl/sad_result_reg.sv
// rtl/sad_result_reg.sv - window result capture register with valid/ready hold
module sad_result_reg #(
   parameter int N_FLAG = 600,
   parameter int ROW_AW = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              capture,
   input  logic [N_FLAG-1:0] flags_in,
   input  logic [ROW_AW-1:0] row_in,
   input  logic              ready,
   output logic              valid,
   output logic [N_FLAG-1:0] flags,
   output logic [ROW_AW-1:0] row
);
   // Flags and row only load on capture, so they stay frozen under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         flags <= '0;
         row   <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
         flags <= flags_in;
         row   <= row_in;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/sad_scan_controller.sv
// rtl/sad_scan_controller.sv - window sequencer for the vertical SAD processor array
module sad_scan_controller #(
   parameter int IMG_H    = sad_pkg::IMG_H,
   parameter int TPL_W    = sad_pkg::TPL_W,
   parameter int TPL_H    = sad_pkg::TPL_H,
   parameter int N_FLAG   = sad_pkg::N_FLAG,
   parameter int PIPE_LAT = sad_pkg::PIPE_LAT,
   parameter int ROW_AW   = sad_pkg::ROW_AW,
   parameter int TPL_AW   = sad_pkg::TPL_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              img_row_req,
   output logic [ROW_AW-1:0] img_row_addr,
   input  logic              img_row_valid,
   output logic [TPL_AW-1:0] tpl_addr,
   output logic              tpl_en,
   output logic              change_row,
   output logic              pe_clear,
   input  logic [N_FLAG-1:0] sad_flag_in,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [ROW_AW-1:0] result_row,
   output logic [N_FLAG-1:0] result_flags
);
   import sad_pkg::*;

   localparam int T_W = (TPL_H > 1) ? $clog2(TPL_H) : 1;
   localparam int C_W = (TPL_W > 1) ? $clog2(TPL_W) : 1;
   localparam int W_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [ROW_AW-1:0] Y_LAST = ROW_AW'(IMG_H - TPL_H);
   localparam logic [T_W-1:0]    T_LAST = T_W'(TPL_H - 1);
   localparam logic [C_W-1:0]    C_LAST = C_W'(TPL_W - 1);
   localparam logic [W_W-1:0]    W_LAST = W_W'(PIPE_LAT - 1);

   scan_state_t       state;
   logic [ROW_AW-1:0] y;
   logic [T_W-1:0]    t;
   logic [C_W-1:0]    c;
   logic [W_W-1:0]    w;
   logic              capture;

   // Sample the array flags on the last wait cycle, PIPE_LAT after the final change_row.
   assign capture = (state == S_WAIT) && (w == W_LAST) && !abort;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         img_row_req  <= 1'b0;
         img_row_addr <= '0;
         tpl_addr     <= '0;
         tpl_en       <= 1'b0;
         change_row   <= 1'b0;
         pe_clear     <= 1'b0;
         y            <= '0;
         t            <= '0;
         c            <= '0;
         w            <= '0;
      end else if (abort) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         img_row_req <= 1'b0;
         tpl_en      <= 1'b0;
         change_row  <= 1'b0;
         pe_clear    <= 1'b0;
      end else begin
         done       <= 1'b0;
         pe_clear   <= 1'b0;
         change_row <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_CLEAR;
                  busy     <= 1'b1;
                  y        <= '0;
                  pe_clear <= 1'b1;
               end
            end
            S_CLEAR: begin
               t            <= '0;
               img_row_req  <= 1'b1;
               img_row_addr <= y;
               state        <= S_FETCH;
            end
            S_FETCH: begin
               if (img_row_valid) begin
                  img_row_req <= 1'b0;
                  c           <= '0;
                  tpl_en      <= 1'b1;
                  tpl_addr    <= TPL_AW'(t) * TPL_AW'(TPL_W);
                  state       <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (c == C_LAST) begin
                  tpl_en     <= 1'b0;
                  change_row <= 1'b1;
                  state      <= S_ROWCHG;
               end else begin
                  c        <= c + C_W'(1);
                  tpl_addr <= tpl_addr + TPL_AW'(1);
               end
            end
            S_ROWCHG: begin
               if (t != T_LAST) begin
                  t            <= t + T_W'(1);
                  img_row_req  <= 1'b1;
                  img_row_addr <= y + ROW_AW'(t) + ROW_AW'(1);
                  state        <= S_FETCH;
               end else begin
                  w     <= '0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w == W_LAST) begin
                  state <= S_REPORT;
               end else begin
                  w <= w + W_W'(1);
               end
            end
            S_REPORT: begin
               if (result_ready) begin
                  if (y != Y_LAST) begin
                     y        <= y + ROW_AW'(1);
                     pe_clear <= 1'b1;
                     state    <= S_CLEAR;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   sad_result_reg #(
      .N_FLAG(N_FLAG),
      .ROW_AW(ROW_AW)
   ) u_result (
      .clk     (clk),
      .rst     (rst),
      .clear   (abort),
      .capture (capture),
      .flags_in(sad_flag_in),
      .row_in  (y),
      .ready   (result_ready),
      .valid   (result_valid),
      .flags   (result_flags),
      .row     (result_row)
   );
endmodule

// File: tb/tb_sad_scan_controller.sv
// tb/tb_sad_scan_controller.sv - self-checking bench for sad_scan_controller
`timescale 1ns/1ps
module tb_sad_scan_controller;
   localparam int S_IMG_H = 6;
   localparam int S_TPL_H = 2;
   localparam int S_TPL_W = 4;
   localparam int S_LAT   = 2;
   localparam int NF      = 600;
   localparam int RAW     = 9;
   localparam int TAW     = 11;
   localparam int NWIN    = S_IMG_H - S_TPL_H + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // small-configuration instance
   logic           rst = 1'b0, start = 1'b0, abort = 1'b0;
   logic           img_row_valid = 1'b0, result_ready = 1'b0;
   logic [NF-1:0]  sad_flag_in = '0;
   logic           busy, done, img_row_req, tpl_en, change_row, pe_clear, result_valid;
   logic [RAW-1:0] img_row_addr, result_row;
   logic [TAW-1:0] tpl_addr;
   logic [NF-1:0]  result_flags;

   // full-size instance
   logic           f_rst = 1'b0, f_start = 1'b0, f_abort = 1'b0;
   logic           f_img_row_valid = 1'b0, f_result_ready = 1'b1;
   logic [NF-1:0]  f_sad_flag_in = '0;
   logic           f_busy, f_done, f_img_row_req, f_tpl_en, f_change_row, f_pe_clear, f_result_valid;
   logic [RAW-1:0] f_img_row_addr, f_result_row;
   logic [TAW-1:0] f_tpl_addr;
   logic [NF-1:0]  f_result_flags;

   sad_scan_controller #(
      .IMG_H(S_IMG_H), .TPL_W(S_TPL_W), .TPL_H(S_TPL_H), .N_FLAG(NF),
      .PIPE_LAT(S_LAT), .ROW_AW(RAW), .TPL_AW(TAW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .img_row_req(img_row_req), .img_row_addr(img_row_addr), .img_row_valid(img_row_valid),
      .tpl_addr(tpl_addr), .tpl_en(tpl_en), .change_row(change_row), .pe_clear(pe_clear),
      .sad_flag_in(sad_flag_in), .result_valid(result_valid), .result_ready(result_ready),
      .result_row(result_row), .result_flags(result_flags)
   );

   sad_scan_controller dut_full (
      .clk(clk), .rst(f_rst), .start(f_start), .abort(f_abort), .busy(f_busy), .done(f_done),
      .img_row_req(f_img_row_req), .img_row_addr(f_img_row_addr), .img_row_valid(f_img_row_valid),
      .tpl_addr(f_tpl_addr), .tpl_en(f_tpl_en), .change_row(f_change_row), .pe_clear(f_pe_clear),
      .sad_flag_in(f_sad_flag_in), .result_valid(f_result_valid), .result_ready(f_result_ready),
      .result_row(f_result_row), .result_flags(f_result_flags)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   task automatic check_vec(input string name, input logic [NF-1:0] act, input logic [NF-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      n_total++;
      $display("FAIL %s: got %0d required no event", name, act);
   endtask

   // per-window stimulus and expected result
   typedef struct {
      int             fetch_dly;
      int             ready_dly;
      int             mode;
      int             exp_row;
      logic [NF-1:0]  exp_flags;
   } win_vec_t;
   win_vec_t vec [NWIN];

   typedef struct {
      logic [RAW-1:0] row;
      logic [NF-1:0]  flags;
   } res_t;
   res_t q_res[$];
   int   q_row[$];
   int   q_tpl[$];

   function automatic logic [NF-1:0] pat(input int k);
      logic [29:0] s;
      s = 30'(k * 40503 + 7);
      return {20{s}};
   endfunction

   function automatic logic [NF-1:0] marker();
      logic [NF-1:0] m;
      m = '0;
      m[0] = 1'b1;
      m[NF-1] = 1'b1;
      return m;
   endfunction

   function automatic logic [NF-1:0] rnd600();
      logic [NF-1:0] r;
      for (int i = 0; i < 20; i++) r[i*30 +: 30] = 30'($urandom);
      return r;
   endfunction

   function automatic logic [NF-1:0] early_val(input int k);
      case (vec[k].mode)
         0:       return ~pat(k);
         1:       return '0;
         default: return marker();
      endcase
   endfunction

   // reactive row buffer, flag source, result sink and monitor for the small instance
   int   cyc = 0, clr_cnt = 0, crow_cnt = 0, acc_cnt = 0, done_cnt = 0, viol = 0;
   int   req_cnt = 0, rv_cnt = 0, off = 100, last_acc_cyc = 0, done_cyc = 0;
   logic prev_fetch_acc = 1'b0, prev_res_acc = 1'b0, prev_valid = 1'b0;
   logic [RAW-1:0] req_addr0 = '0, snap_row = '0;
   logic [NF-1:0]  snap_flags = '0;

   always @(negedge clk) begin
      int win;
      cyc++;
      if (!rst) begin
         img_row_valid = 1'b0;
         result_ready  = 1'b0;
         sad_flag_in   = '0;
         req_cnt = 0; rv_cnt = 0; off = 100;
         prev_fetch_acc = 1'b0; prev_res_acc = 1'b0; prev_valid = 1'b0;
      end else begin
         if (pe_clear) clr_cnt++;
         win = clr_cnt - 1;
         if (win < 0) win = 0;
         if (win >= NWIN) win = NWIN - 1;
         if (int'(tpl_en) + int'(change_row) + int'(pe_clear) > 1) viol++;
         if (img_row_req && tpl_en) viol++;
         if (prev_fetch_acc && (img_row_req || !tpl_en)) viol++;
         if (prev_res_acc && result_valid) viol++;
         if (result_valid && pe_clear) viol++;
         if (change_row) begin
            crow_cnt++;
            off = 0;
         end else if (off < 100) off++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (tpl_en) begin
            if (q_tpl.size() == 0) unexpected("tpl_addr_extra", 64'(tpl_addr));
            else check("tpl_addr", 64'(tpl_addr), 64'(q_tpl.pop_front()));
         end
         prev_fetch_acc = 1'b0;
         if (img_row_req) begin
            if (req_cnt == 0) req_addr0 = img_row_addr;
            else if (img_row_addr != req_addr0) viol++;
            if (req_cnt >= vec[win].fetch_dly) begin
               img_row_valid  = 1'b1;
               prev_fetch_acc = 1'b1;
               if (q_row.size() == 0) unexpected("row_req_extra", 64'(img_row_addr));
               else check("img_row_addr", 64'(img_row_addr), 64'(q_row.pop_front()));
            end else img_row_valid = 1'b0;
            req_cnt++;
         end else begin
            req_cnt = 0;
            img_row_valid = 1'b0;
         end
         prev_res_acc = 1'b0;
         if (result_valid) begin
            if (!prev_valid) begin
               snap_flags = result_flags;
               snap_row   = result_row;
            end else if (result_flags != snap_flags || result_row != snap_row) viol++;
            if (rv_cnt >= vec[win].ready_dly) begin
               result_ready = 1'b1;
               prev_res_acc = 1'b1;
               acc_cnt++;
               last_acc_cyc = cyc;
               if (q_res.size() == 0) unexpected("result_extra", 64'(result_row));
               else begin
                  res_t e;
                  e = q_res.pop_front();
                  check("result_row", 64'(result_row), 64'(e.row));
                  check_vec("result_flags", result_flags, e.flags);
               end
            end else result_ready = 1'b0;
            rv_cnt++;
         end else begin
            rv_cnt = 0;
            result_ready = 1'b0;
         end
         prev_valid = result_valid;
         if (off == S_LAT) sad_flag_in = vec[win].exp_flags;
         else if (off == S_LAT - 1) sad_flag_in = early_val(win);
         else sad_flag_in = rnd600();
      end
   end

   task automatic arm(input int nwin);
      q_row.delete(); q_tpl.delete(); q_res.delete();
      for (int k = 0; k < nwin; k++) begin
         for (int tt = 0; tt < S_TPL_H; tt++) q_row.push_back(k + tt);
         for (int a = 0; a < S_TPL_W * S_TPL_H; a++) q_tpl.push_back(a);
         q_res.push_back('{row: RAW'(vec[k].exp_row), flags: vec[k].exp_flags});
      end
      clr_cnt = 0; crow_cnt = 0; acc_cnt = 0; done_cnt = 0; viol = 0;
   endtask

   task automatic run_scan(input string tag);
      bit ok;
      arm(NWIN);
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
      ok = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk); #1;
         start = (n == 30);
         if (done_cnt > 0) begin
            ok = 1;
            break;
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 64'(ok), 64'd1);
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check({tag, "_accepts"}, 64'(acc_cnt), 64'(NWIN));
      check({tag, "_pe_clears"}, 64'(clr_cnt), 64'(NWIN));
      check({tag, "_change_rows"}, 64'(crow_cnt), 64'(NWIN * S_TPL_H));
      check({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_acc_cyc + 1));
      check({tag, "_rows_left"}, 64'(q_row.size()), 64'd0);
      check({tag, "_tpl_left"}, 64'(q_tpl.size()), 64'd0);
      check({tag, "_results_left"}, 64'(q_res.size()), 64'd0);
      repeat (4) @(negedge clk);
      #1;
      check({tag, "_done_single"}, 64'(done_cnt), 64'd1);
      check({tag, "_protocol_viol"}, 64'(viol), 64'd0);
   endtask

   initial begin
      bit hit;
      vec[0] = '{fetch_dly: 0, ready_dly: 0,  mode: 0, exp_row: 0, exp_flags: '0};
      vec[1] = '{fetch_dly: 3, ready_dly: 0,  mode: 1, exp_row: 1, exp_flags: '0};
      vec[2] = '{fetch_dly: 0, ready_dly: 10, mode: 0, exp_row: 2, exp_flags: '0};
      vec[3] = '{fetch_dly: 1, ready_dly: 2,  mode: 2, exp_row: 3, exp_flags: '0};
      vec[4] = '{fetch_dly: 0, ready_dly: 0,  mode: 0, exp_row: 4, exp_flags: '0};
      for (int i = 0; i < NWIN; i++)
         vec[i].exp_flags = (vec[i].mode == 0) ? pat(i) : (vec[i].mode == 1) ? marker() : '0;

      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_req", 64'(img_row_req), 64'd0);
      check("rst_row_addr", 64'(img_row_addr), 64'd0);
      check("rst_tpl_en", 64'(tpl_en), 64'd0);
      check("rst_tpl_addr", 64'(tpl_addr), 64'd0);
      check("rst_strobes", 64'({change_row, pe_clear}), 64'd0);
      check("rst_result_valid", 64'(result_valid), 64'd0);
      check("rst_result_row", 64'(result_row), 64'd0);
      check_vec("rst_result_flags", result_flags, '0);
      rst = 1'b1;
      f_rst = 1'b1;

      // full-size scan interrupted by reset at t=3, c=17
      @(negedge clk); f_start = 1'b1;
      @(negedge clk); f_start = 1'b0;
      hit = 0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         f_img_row_valid = f_img_row_req;
         if (f_tpl_en && f_tpl_addr == TAW'(3 * 40 + 17)) begin
            hit = 1;
            break;
         end
      end
      check("full_reach_t3_c17", 64'(hit), 64'd1);
      check("full_busy_mid", 64'(f_busy), 64'd1);
      #2 f_rst = 1'b0;
      #1;
      check("full_async_busy", 64'(f_busy), 64'd0);
      check("full_async_tpl_en", 64'(f_tpl_en), 64'd0);
      check("full_async_tpl_addr", 64'(f_tpl_addr), 64'd0);
      check("full_async_req", 64'({f_img_row_req, f_img_row_addr}), 64'd0);
      check("full_async_strobes", 64'({f_change_row, f_pe_clear, f_done, f_result_valid}), 64'd0);
      f_img_row_valid = 1'b0;
      repeat (2) @(negedge clk);
      f_rst = 1'b1;
      repeat (5) @(negedge clk);
      check("full_idle_busy", 64'(f_busy), 64'd0);
      check("full_idle_activity", 64'({f_tpl_en, f_img_row_req, f_pe_clear}), 64'd0);

      run_scan("scan1");

      // abort in REPORT with result_ready high in the same cycle
      arm(1);
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      hit = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (result_valid) begin
            hit = 1;
            break;
         end
      end
      check("abort_reached_report", 64'(hit), 64'd1);
      #1;
      check("abort_ready_same_cycle", 64'(result_ready), 64'd1);
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
      check("abort_result_valid", 64'(result_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_strobes", 64'({done, tpl_en, img_row_req, pe_clear, change_row}), 64'd0);
      repeat (5) @(negedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_stays_idle", 64'({busy, pe_clear, img_row_req}), 64'd0);

      run_scan("restart");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/sad_scan_controller.md
Name: sad_scan_controller

Overview:
- Sequencer for the 640-column vertical SAD processor array. It steps a TPL_W x TPL_H binary template down the image one window row at a time.
- For each window it fetches the TPL_H image rows, broadcasts template bits serially, and pulses the row-change control after each template row.
- After each window it captures the array's 600-bit sad_flag vector and hands it downstream with a valid/ready handshake.
- Sits between the image row buffer, the template ROM and the vertical processor array.

Parameters:
IMG_H, 480, image height in rows
TPL_W, 40, template width (bits streamed per template row)
TPL_H, 40, template height (template rows per window)
N_FLAG, 600, number of valid SAD columns (640 - TPL_W)
PIPE_LAT, 2, cycles from last change_row until sad_flag_in is valid
ROW_AW, 9, width of image row address
TPL_AW, 11, width of template bit address

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a full-image scan when IDLE
abort  in  1  synchronous; returns to IDLE at the next edge from any state
busy  out  1  high from the start acceptance cycle until DONE is entered
done  out  1  one-cycle pulse when the last window's result is accepted
img_row_req  out  1  request image row img_row_addr
img_row_addr  out  ROW_AW  image row being requested
img_row_valid  in  1  row buffer has driven the array's original[639:0] inputs
tpl_addr  out  TPL_AW  template bit index = t*TPL_W + c
tpl_en  out  1  template bit on the array input is valid this cycle
change_row  out  1  one-cycle pulse to the array after each template row
pe_clear  out  1  one-cycle pulse; zeroes the array SAD accumulators
sad_flag_in  in  N_FLAG  flag vector from the array
result_valid  out  1  result_row/result_flags hold a window result
result_ready  in  1  downstream accepts the result
result_row  out  ROW_AW  top image row y of the reported window
result_flags  out  N_FLAG  captured sad_flag_in

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters y, t, c cleared.
- Counters:
  - y: window top row, range 0..IMG_H-TPL_H.
  - t: template row, range 0..TPL_H-1.
  - c: template column, range 0..TPL_W-1.
  - w: latency counter.
- States:
  - IDLE: start=1 -> CLEAR with y=0; busy=1 from this edge.
  - CLEAR: pe_clear=1 for exactly one cycle; t=0 -> FETCH.
  - FETCH:
    - img_row_req=1 and img_row_addr=y+t, held stable until img_row_valid=1.
    - On the valid cycle, drop req at the next edge; c=0 -> STREAM.
    - Zero-wait valid (same cycle as req) is legal.
  - STREAM:
    - tpl_en=1 and tpl_addr=t*TPL_W+c for TPL_W consecutive cycles.
    - On c=TPL_W-1 -> ROWCHG.
  - ROWCHG: change_row=1 for one cycle.
    - If t<TPL_H-1: t++ -> FETCH.
    - Otherwise: w=0 -> WAIT.
  - WAIT: count PIPE_LAT cycles; on the final cycle sample sad_flag_in into result_flags and y into result_row -> REPORT.
  - REPORT: result_valid=1; flags and row held stable until result_ready=1.
    - On acceptance, if y<IMG_H-TPL_H: y++ -> CLEAR.
    - Otherwise -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Cycles per window = 1 + TPL_H*(F+TPL_W+1) + PIPE_LAT + R, where F is the fetch latency (>=1) and R is the REPORT wait (>=1).
- start is ignored while busy=1.
- abort wins over every other transition, including a same-cycle result_ready:
  - Next edge: IDLE, all strobes 0, result_valid 0, busy 0, no done pulse.
  - The array is not cleared until the next scan's CLEAR.
- result_valid never drops without acceptance, except on abort or reset.
- tpl_en, change_row and pe_clear are mutually exclusive in every cycle.
- Address arithmetic is unsigned, with no wrap:
  - y+t <= IMG_H-1 always holds.
  - tpl_addr max = TPL_W*TPL_H-1 = 1599.
- Asserting reset mid-scan forces the IDLE/zero state immediately.

Decomposition:
- Shared package sad_pkg:
  - Constants IMG_W=640, IMG_H, TPL_W, TPL_H, N_FLAG, SAD_THRESH=500.
  - State enum type scan_state_t.
  - Derived widths ROW_AW and TPL_AW (clog2).
- One natural sub-module, sad_result_reg: the N_FLAG-wide capture register with valid/ready hold logic. The FSM and counters stay in the top module.

Test Plan:
- Reset mid-STREAM (rst low at t=3, c=17) -> all outputs 0 asynchronously; after release, stays IDLE with busy=0.
- Small config (IMG_H=6, TPL_H=2, TPL_W=4, PIPE_LAT=2), start, zero-wait row buffer, result_ready=1 -> required response:
  - Exactly 5 result_valid pulses with result_row=0..4.
  - Row requests 0,1,1,2,2,3,3,4,4,5.
  - tpl_addr sequence 0..7 per window.
  - 5 pe_clear pulses and 10 change_row pulses; done after the last result.
- img_row_valid delayed 3 cycles -> img_row_addr stable and req high for 4 cycles; no tpl_en during FETCH.
- Backpressure: result_ready low for 10 cycles with sad_flag_in toggling -> result_flags and result_row frozen; no pe_clear until acceptance.
- Check the PIPE_LAT capture point: a sad_flag_in pattern of bit0=1 and bit599=1 presented exactly PIPE_LAT cycles after the last change_row -> captured; the same pattern shifted one cycle early -> not captured.
- abort during REPORT with result_ready=1 in the same cycle -> IDLE next edge, no done pulse, result_valid=0; a new start then restarts at img_row_addr=0.
